// File: rtl/excp_collect_pkg.sv
// ============================================================================
// excp_collect_pkg : error-bit map, memory access size and stage record type
// Revision: 1.0
// ============================================================================
`default_nettype none

package excp_collect_pkg;

  localparam int ERR_W = 12;

  localparam int ERR_RI     = 0;
  localparam int ERR_SYS    = 1;
  localparam int ERR_BP     = 2;
  localparam int ERR_ERET   = 3;
  localparam int ERR_ADES   = 4;
  localparam int ERR_ADEL_D = 5;
  localparam int ERR_ADEL_F = 6;
  localparam int ERR_OV     = 7;
  localparam int ERR_DS     = 8;
  localparam int ERR_MTC0   = 11;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_size_t;

  typedef struct packed {
    logic             valid;
    logic [31:0]      pc;
    logic [ERR_W-1:0] err;
    logic [31:0]      badv;
  } stage_t;

endpackage

`default_nettype wire

// File: rtl/excp_collect_if.sv
// ============================================================================
// excp_collect_if : exception report presented to CP0 from the M stage
// Revision: 1.0
// ============================================================================
`default_nettype none

interface excp_collect_if;
  import excp_collect_pkg::*;

  logic [ERR_W-1:0] error;
  logic [31:0]      BadVaddr;
  logic [31:0]      pcM;
  logic             validM;

  modport master (output error, BadVaddr, pcM, validM);
  modport slave  (input  error, BadVaddr, pcM, validM);
endinterface

`default_nettype wire

// File: rtl/excp_collect_addr_align_chk.sv
// ============================================================================
// addr_align_chk : flags an address not naturally aligned to the access size
// Revision: 1.0
// ============================================================================
`default_nettype none

module addr_align_chk
  import excp_collect_pkg::*;
(
  input  mem_size_t  size,
  input  logic [1:0] addr_lo,
  output logic       misaligned
);

  always_comb begin
    misaligned = 1'b0;
    case (size)
      SIZE_HALF: misaligned = addr_lo[0];
      SIZE_WORD: misaligned = |addr_lo;
      default:   misaligned = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/excp_collect.sv
// ============================================================================
// excp_collect : collects F/D/E exception events and carries them to M for CP0
// Revision: 1.0
// ============================================================================
`default_nettype none

module excp_collect
  import excp_collect_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pcF,
  input  logic        validF,
  input  logic        ri_d,
  input  logic        syscall_d,
  input  logic        break_d,
  input  logic        eret_d,
  input  logic        mtc0_d,
  input  logic        branch_d,
  input  logic        ov_e,
  input  logic        mem_ren_e,
  input  logic        mem_wen_e,
  input  logic [1:0]  mem_size_e,
  input  logic [31:0] mem_addr_e,
  input  logic        stall_d,
  input  logic        stall_e,
  input  logic        stall_m,
  input  logic        flush,
  excp_collect_if.master cp0
);

  stage_t r_d;
  stage_t r_e;
  stage_t r_m;
  logic   r_ds_pend;

  stage_t w_d_nxt;
  stage_t w_e_nxt;
  stage_t w_m_nxt;
  logic   w_fetch_mis;
  logic   w_data_mis;
  logic   w_br_move;
  logic   w_ds_in;
  logic   w_dec_ok;
  logic   w_ex_ok;
  logic   w_ov;
  logic   w_adel;
  logic   w_ades;

  addr_align_chk u_fetch_chk (
    .size       (SIZE_WORD),
    .addr_lo    (pcF[1:0]),
    .misaligned (w_fetch_mis)
  );

  addr_align_chk u_data_chk (
    .size       (mem_size_t'(mem_size_e)),
    .addr_lo    (mem_addr_e[1:0]),
    .misaligned (w_data_mis)
  );

  // The delay slot enters D on the same edge its branch leaves, so it must
  // see the branch move directly, not only the registered pending flag.
  assign w_br_move = r_d.valid & branch_d & ~stall_d & ~stall_e & ~flush;
  assign w_ds_in   = r_ds_pend | w_br_move;

  always_comb begin
    w_d_nxt                 = '0;
    w_d_nxt.valid           = validF;
    w_d_nxt.pc              = pcF;
    w_d_nxt.err[ERR_ADEL_F] = validF & w_fetch_mis;
    w_d_nxt.err[ERR_DS]     = validF & w_ds_in;
    w_d_nxt.badv            = (validF & w_fetch_mis) ? pcF : 32'h0;
  end

  always_comb begin
    w_e_nxt               = r_d;
    w_dec_ok              = r_d.valid & ~r_d.err[ERR_ADEL_F];
    w_e_nxt.err[ERR_RI]   = r_d.err[ERR_RI]   | (w_dec_ok & ri_d);
    w_e_nxt.err[ERR_SYS]  = r_d.err[ERR_SYS]  | (w_dec_ok & syscall_d);
    w_e_nxt.err[ERR_BP]   = r_d.err[ERR_BP]   | (w_dec_ok & break_d);
    w_e_nxt.err[ERR_ERET] = r_d.err[ERR_ERET] | (w_dec_ok & eret_d);
    w_e_nxt.err[ERR_MTC0] = mtc0_d & r_d.valid & ~(|w_e_nxt.err[7:0]);
  end

  // Only an instruction still clean at E may pick up E-stage faults.
  always_comb begin
    w_m_nxt = r_e;
    w_ex_ok = r_e.valid & ~(|r_e.err[7:0]);
    w_ov    = w_ex_ok & ov_e;
    w_adel  = w_ex_ok & mem_ren_e & w_data_mis;
    w_ades  = w_ex_ok & mem_wen_e & w_data_mis;
    w_m_nxt.err[ERR_OV]     = r_e.err[ERR_OV]     | w_ov;
    w_m_nxt.err[ERR_ADEL_D] = r_e.err[ERR_ADEL_D] | w_adel;
    w_m_nxt.err[ERR_ADES]   = r_e.err[ERR_ADES]   | w_ades;
    if (w_adel | w_ades) begin
      w_m_nxt.badv = mem_addr_e;
    end
    if (w_ov | w_adel | w_ades) begin
      w_m_nxt.err[ERR_MTC0] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_d       <= '0;
      r_e       <= '0;
      r_m       <= '0;
      r_ds_pend <= 1'b0;
    end else if (flush) begin
      r_d       <= '0;
      r_e       <= '0;
      r_m       <= '0;
      r_ds_pend <= 1'b0;
    end else begin
      if (!stall_d) begin
        r_d <= w_d_nxt;
      end
      if (!stall_e) begin
        r_e <= stall_d ? '0 : w_e_nxt;
      end
      if (!stall_m) begin
        r_m <= stall_e ? '0 : w_m_nxt;
      end
      if (!stall_d && validF) begin
        r_ds_pend <= 1'b0;
      end else if (w_br_move) begin
        r_ds_pend <= 1'b1;
      end
    end
  end

  assign cp0.error    = r_m.valid ? r_m.err : '0;
  assign cp0.BadVaddr = r_m.badv;
  assign cp0.pcM      = r_m.pc;
  assign cp0.validM   = r_m.valid;

endmodule

`default_nettype wire
